// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl -- bit-serial adder controller.
//
// Adds A + B + Cin one bit per clock, LSB first, through a single
// full_adder cell. A request on start is accepted in IDLE or DONE; the
// operands are captured at that edge, so the inputs may change freely
// afterwards. The result appears on Sum/Cout at the edge entering DONE
// and holds there until the next completion.
//
// Ports
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   request; sampled in IDLE and DONE, ignored in ADD
//   A, B   in   WIDTH-bit operands, captured when start is accepted
//   Cin    in   carry-in, captured when start is accepted
//   busy   out  high while bits are being added (state ADD)
//   done   out  one-cycle completion strobe (state DONE)
//   Sum    out  WIDTH-bit result of the last completed addition
//   Cout   out  carry-out of the last completed addition

module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; Sum/Cout hold the last result
// ADD   | one operand bit per edge through the full adder; busy=1
// DONE  | result just loaded, done=1 for one cycle; start is accepted

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);
    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] psum;
    logic [WIDTH-1:0] psum_next;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             fa_s;
    logic             fa_co;

    // Operands shift right every ADD cycle, so bit 0 of each shift register
    // always holds original operand bit [cnt].
    full_adder u_fa (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // Each new sum bit enters at the MSB. After WIDTH shifts the first bit
    // computed has reached bit 0. Written as shift/or so that WIDTH=1 works.
    always_comb begin
        psum_next = (psum >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            Sum   <= '0;
            Cout  <= 1'b0;
            cnt   <= '0;
            carry <= 1'b0;
            a_sr  <= '0;
            b_sr  <= '0;
            psum  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr  <= A;
                        b_sr  <= B;
                        carry <= Cin;
                        cnt   <= '0;
                        psum  <= '0;
                        busy  <= 1'b1;
                        state <= ADD;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                ADD: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    psum  <= psum_next;
                    carry <= fa_co;
                    if (cnt == LAST) begin
                        Sum   <= psum_next;
                        Cout  <= fa_co;
                        cnt   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 1..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request pulse/level; sampled on rising clk.
REQ-005 A  input  WIDTH  operand A, sampled only when start is accepted.
REQ-006 B  input  WIDTH  operand B, sampled only when start is accepted.
REQ-007 Cin  input  1  carry-in, sampled only when start is accepted.
REQ-008 busy  output  1  high while an addition is in progress.
REQ-009 done  output  1  one-cycle completion strobe.
REQ-010 Sum  output  WIDTH  registered result of last completed addition.
REQ-011 Cout  output  1  registered carry-out of last completed addition.

Function
REQ-012 The block SHALL compute A+B+Cin bit-serially, LSB first, through exactly one full_adder instance; no WIDTH-wide adder.
REQ-013 FSM states SHALL be IDLE, ADD, DONE; encoding free.
REQ-014 IDLE: start=1 at an edge -> latch A, B, Cin into shift/carry registers, clear bit counter to 0, go to ADD; start=0 -> stay IDLE.
REQ-015 ADD: each edge SHALL feed operand bit [cnt] and the carry register to the full_adder, shift its sum into a partial-sum register, store its carry, increment cnt.
REQ-016 ADD: on the edge processing bit WIDTH-1, the block SHALL load Sum with the complete partial sum, Cout with the final carry, and go to DONE.
REQ-017 DONE: lasts exactly one cycle; start=1 -> accepted as in IDLE (go to ADD); else go to IDLE.
REQ-018 Latency: start accepted at edge t0 -> done=1 during the cycle after edge t0+WIDTH; back-to-back throughput one result per WIDTH+1 cycles.
REQ-019 busy SHALL be 1 exactly in state ADD; done SHALL be 1 exactly in state DONE.
REQ-020 start SHALL be ignored while in ADD; operand inputs may change freely after acceptance without affecting the result.
REQ-021 Sum and Cout SHALL change only on the edge entering DONE and hold until the next completion; partial results SHALL never appear on Sum/Cout.
REQ-022 Result SHALL equal (A+B+Cin) mod 2^WIDTH on Sum, bit WIDTH on Cout, for all operands including all-ones wrap-around.
REQ-023 cnt width SHALL be clog2(WIDTH) bits minimum, 1 bit for WIDTH=1; counter never exceeds WIDTH-1.

Reset
REQ-024 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, Sum=0, Cout=0, cnt=0, carry register=0, independent of clk.
REQ-025 Reset during ADD SHALL abort the operation with no done pulse; Sum/Cout SHALL read 0.
REQ-026 After rst_n deasserts, the first start SHALL be accepted on the first rising edge where rst_n=1 and start=1.

Verification
REQ-027 WIDTH=8, A=8'hFF, B=8'h01, Cin=0, start 1 cycle -> busy 8 cycles, done 1 cycle, Sum=8'h00, Cout=1.
REQ-028 WIDTH=8, A=8'h5A, B=8'h3C, Cin=1 -> Sum=8'h97, Cout=0; operands changed to 8'h00 mid-ADD give the same result.
REQ-029 start held high continuously with A=8'h01, B=8'h01, Cin=0 -> one done every 9 cycles, Sum=8'h02 each time; start pulses during busy produce no extra done.
REQ-030 rst_n pulled low at cycle 4 of ADD -> busy, done, Sum, Cout all 0 asynchronously; no done afterwards until a new start.
REQ-031 WIDTH=1, A=1, B=1, Cin=1 -> busy 1 cycle, then Sum=1, Cout=1, done 1 cycle.
REQ-032 Random regression: 1000 random A, B, Cin at WIDTH=8 and WIDTH=32 -> Sum/Cout match reference sum at every done.
